// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//
// Shares one single-port RAM between an instruction-fetch requester and a
// data load/store requester. Each granted access is latched, presented to
// the RAM until ram_ack, and completed with a one-cycle hit pulse on the
// side that owns it. If the RAM never answers, the access is dropped after
// TIMEOUT waiting cycles and err pulses for one cycle instead of a hit.
//
// Parameters
//   ADDR_W   memory address width
//   DATA_W   memory word width
//   TIMEOUT  cycles to wait for ram_ack before aborting (must be >= 1)
//
// Ports
//   CLK, nRST              clock, asynchronous active-low reset
//   imemREN, iaddr         instruction read request and address
//   dmemREN, dmemWEN       data read / write request (write wins if both)
//   daddr, dstore          data address and write data
//   ihit, iload            instruction done pulse and fetched word
//   dhit, dload            data done pulse and read word
//   ramREN, ramWEN         RAM read / write strobes
//   ramaddr, ramstore      RAM address and write data
//   ramload, ram_ack       RAM read data and completion pulse
//   err                    one-cycle timeout pulse
// -----------------------------------------------------------------------------
module mem_req_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic              dhit,
    output logic [DATA_W-1:0] iload,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ack,
    output logic              err
);

    // The counter only needs to hold 0 .. TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             last_data;   // previous grant went to the data side
    logic             data_req;
    logic             grant_data;

    assign data_req = dmemREN | dmemWEN;
    // Data normally wins; after a data grant a waiting fetch gets one turn so
    // a stream of loads/stores cannot starve instruction fetch.
    assign grant_data = data_req & ~(last_data & imemREN);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            last_data <= 1'b0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            err       <= 1'b0;
            iload     <= '0;
            dload     <= '0;
            ramREN    <= 1'b0;
            ramWEN    <= 1'b0;
            ramaddr   <= '0;
            ramstore  <= '0;
        end else begin
            // Pulses last exactly one cycle unless re-armed below.
            ihit <= 1'b0;
            dhit <= 1'b0;
            err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state     <= DATA;
                        ramaddr   <= daddr;
                        ramstore  <= dstore;
                        ramWEN    <= dmemWEN;
                        ramREN    <= ~dmemWEN;
                        last_data <= 1'b1;
                        wait_cnt  <= '0;
                    end else if (imemREN) begin
                        state     <= INST;
                        ramaddr   <= iaddr;
                        ramWEN    <= 1'b0;
                        ramREN    <= 1'b1;
                        last_data <= 1'b0;
                        wait_cnt  <= '0;
                    end
                end

                DATA, INST: begin
                    if (ram_ack) begin
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        state  <= DONE;
                        if (state == DATA) begin
                            dhit  <= 1'b1;
                            dload <= ramload;
                        end else begin
                            ihit  <= 1'b1;
                            iload <= ramload;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        // RAM never answered: drop the access, no hit.
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        err    <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                // Hit cycle; requests are deliberately not sampled here so a
                // request still high during its own hit is not relaunched.
                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 15;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          imemREN, dmemREN, dmemWEN;
    logic [AW-1:0] iaddr, daddr;
    logic [DW-1:0] dstore;
    logic          ihit, dhit, err;
    logic [DW-1:0] iload, dload;
    logic          ramREN, ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    logic          ram_ack;

    always #5 CLK = ~CLK;

    mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRST(nRST),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ack(ram_ack), .err(err)
    );

    // One expected access: who should own it, what the RAM should see, and
    // how the bench RAM will answer.
    typedef struct {
        bit            is_inst;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] store;
        logic [DW-1:0] rdata;
        int            delay;
        bit            ack;
        bit            tmo;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;
    bit            stray  = 1'b0;
    bit            model_last_data = 1'b0;
    logic [DW-1:0] m_dload = '0;
    logic [DW-1:0] m_iload = '0;
    int            extra_idle = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares RAM-side activity and completions with the queue head.
    initial begin : monitor
        bit   prev_strobe;
        bit   strobe;
        exp_t e;
        prev_strobe = 1'b0;
        forever begin
            @(negedge CLK);
            if (!mon_en) begin
                prev_strobe = 1'b0;
            end else begin
                strobe = ramREN | ramWEN;
                if (strobe) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", 64'(strobe), 64'(0));
                    end else begin
                        e = exp_q[0];
                        check("ramWEN", 64'(ramWEN), 64'(e.wr));
                        check("ramREN", 64'(ramREN), 64'(!e.wr));
                        check("ramaddr", 64'(ramaddr), 64'(e.addr));
                        if (e.wr) check("ramstore", 64'(ramstore), 64'(e.store));
                    end
                end
                if (dhit && ihit) check("both_hits", 64'(1), 64'(0));
                if (dhit || ihit || err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", {61'd0, dhit, ihit, err}, 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("err", 64'(err), 64'(e.tmo));
                        check("ihit", 64'(ihit), 64'(e.is_inst && !e.tmo));
                        check("dhit", 64'(dhit), 64'(!e.is_inst && !e.tmo));
                        if (err) check("strobe_after_err", 64'(strobe), 64'(0));
                        if (!e.tmo) begin
                            if (e.is_inst) m_iload = e.rdata;
                            else           m_dload = e.rdata;
                        end
                    end
                end
                check("dload", 64'(dload), 64'(m_dload));
                check("iload", 64'(iload), 64'(m_iload));
                prev_strobe = strobe;
            end
        end
    end

    // Bench RAM: answers each new strobe after the queued delay, or never.
    initial begin : responder
        bit            prev;
        bit            pending;
        int            cnt;
        logic [DW-1:0] rd;
        ram_ack = 1'b0;
        ramload = '0;
        prev    = 1'b0;
        pending = 1'b0;
        cnt     = 0;
        rd      = '0;
        forever begin
            @(negedge CLK);
            ram_ack = 1'b0;
            ramload = $urandom;
            if (!nRST) begin
                pending = 1'b0;
                prev    = 1'b0;
            end else begin
                if ((ramREN || ramWEN) && !prev && exp_q.size() > 0 && exp_q[0].ack) begin
                    pending = 1'b1;
                    cnt     = exp_q[0].delay;
                    rd      = exp_q[0].rdata;
                end
                if (pending) begin
                    if (cnt == 0) begin
                        ram_ack = 1'b1;
                        ramload = rd;
                        pending = 1'b0;
                    end else begin
                        cnt--;
                    end
                end else if (stray) begin
                    ram_ack = 1'b1;
                end
                prev = ramREN || ramWEN;
            end
        end
    end

    // Called at a negedge with the arbiter idle (or in its hit cycle).
    task automatic do_txn(input bit dr, input bit dw, input bit ir,
                          input logic [AW-1:0] da, input logic [AW-1:0] ia,
                          input logic [DW-1:0] ds, input logic [DW-1:0] rd,
                          input int dly, input bit noack);
        exp_t e;
        bit   gd;
        int   lat;
        int   n;
        bit   done;
        gd        = (dr || dw) && !(model_last_data && ir);
        e.is_inst = !gd;
        e.wr      = gd && dw;
        e.addr    = gd ? da : ia;
        e.store   = ds;
        e.rdata   = rd;
        e.delay   = dly;
        e.ack     = !noack;
        e.tmo     = noack;
        model_last_data = gd;
        exp_q.push_back(e);
        dmemREN = dr; dmemWEN = dw; imemREN = ir;
        daddr = da; iaddr = ia; dstore = ds;
        lat  = (noack ? 1 + TMO : 2 + dly) + extra_idle;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge CLK);
            n++;
            if (dhit || ihit || err) begin
                done = 1'b1;
            end else if (n > TMO + 20) begin
                errors++;
                $display("FAIL txn_wait: no completion after %0d cycles, expected %0d", n, lat);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $fatal(1, "bench stopped: access never completed");
            end
        end
        check("latency", 64'(n), 64'(lat));
        extra_idle = noack ? 0 : 1;
    endtask

    task automatic go_idle(input int cycles);
        dmemREN = 1'b0; dmemWEN = 1'b0; imemREN = 1'b0;
        repeat (cycles) @(negedge CLK);
        extra_idle = 0;
    endtask

    initial begin : stimulus
        bit            dr, dw, ir;
        logic [2:0]    sel;
        exp_t          e;
        nRST = 1'b1;
        dmemREN = 1'b0; dmemWEN = 1'b0; imemREN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        #3 nRST = 1'b0;
        #1;
        check("rst_ihit", 64'(ihit), 64'(0));
        check("rst_dhit", 64'(dhit), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_ramREN", 64'(ramREN), 64'(0));
        check("rst_ramWEN", 64'(ramWEN), 64'(0));
        check("rst_ramaddr", 64'(ramaddr), 64'(0));
        check("rst_ramstore", 64'(ramstore), 64'(0));
        check("rst_iload", 64'(iload), 64'(0));
        check("rst_dload", 64'(dload), 64'(0));
        repeat (2) @(negedge CLK);
        nRST   = 1'b1;
        mon_en = 1'b1;

        // Instruction fetch, ack one cycle after strobe.
        do_txn(0, 0, 1, '0, 32'h0000_0040, '0, 32'h2002_0001, 1, 0);
        // Write + fetch together: write first, then the fetch.
        do_txn(0, 1, 1, 32'h100, 32'h80, 32'hDEAD_BEEF, 32'h1111_2222, 0, 0);
        do_txn(0, 1, 1, 32'h100, 32'h80, 32'hDEAD_BEEF, 32'h3333_4444, 0, 0);
        // Read + fetch held: D, I, D, I.
        for (int i = 0; i < 4; i++)
            do_txn(1, 0, 1, 32'h200 + 32'(i * 4), 32'h300 + 32'(i * 4), '0,
                   32'hA5A5_0000 + 32'(i), i % 3, 0);
        // No ack: timeout.
        do_txn(1, 0, 0, 32'h500, '0, '0, '0, 0, 1);
        go_idle(3);

        // Stray ack while idle.
        @(posedge CLK); #1 stray = 1'b1;
        @(posedge CLK); #1 stray = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("stray_ramREN", 64'(ramREN | ramWEN), 64'(0));
            check("stray_hit", 64'(dhit | ihit | err), 64'(0));
        end
        do_txn(1, 0, 0, 32'h600, '0, '0, 32'h0BAD_F00D, 2, 0);
        go_idle(2);

        // Reset in the middle of a data access, between clock edges.
        e.is_inst = 1'b0; e.wr = 1'b0; e.addr = 32'h700; e.store = '0;
        e.rdata = '0; e.delay = 0; e.ack = 1'b0; e.tmo = 1'b0;
        exp_q.push_back(e);
        model_last_data = 1'b1;
        dmemREN = 1'b1; daddr = 32'h700;
        @(posedge CLK); #1;
        check("pre_rst_ramREN", 64'(ramREN), 64'(1));
        #1 mon_en = 1'b0;
        nRST = 1'b0;
        #1;
        check("async_rst_ramREN", 64'(ramREN), 64'(0));
        check("async_rst_ramWEN", 64'(ramWEN), 64'(0));
        check("async_rst_ramaddr", 64'(ramaddr), 64'(0));
        exp_q.delete();
        model_last_data = 1'b0;
        m_dload = '0;
        m_iload = '0;
        dmemREN = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            check("rst_no_hit", 64'(dhit | ihit | err), 64'(0));
        end
        nRST   = 1'b1;
        mon_en = 1'b1;
        extra_idle = 0;
        do_txn(1, 0, 0, 32'h704, '0, '0, 32'hC0FF_EE00, 0, 0);

        // Randomized mix of requests, delays and timeouts.
        for (int i = 0; i < 150; i++) begin
            sel = 3'($urandom_range(1, 7));
            dr = sel[0]; dw = sel[1]; ir = sel[2];
            do_txn(dr, dw, ir, $urandom, $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
        end
        go_idle(4);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        check("final_strobes", 64'(ramREN | ramWEN), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
